// File: rtl/otbn_edn_packer.sv
// Gathers NumWords narrow EDN words into one wide word for the OTBN RND/URND paths.
// Define OTBN_EDN_REP_CHECK_EN to flag consecutive identical EDN words as errors.
module otbn_edn_packer #(
    parameter int OutW = 256,
    parameter int EdnW = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            req_i,
    output logic            ack_o,
    output logic [OutW-1:0] data_o,
    output logic            fips_o,
    output logic            err_o,
    output logic            edn_req_o,
    input  logic            edn_ack_i,
    input  logic [EdnW-1:0] edn_data_i,
    input  logic            edn_fips_i,
    input  logic            edn_err_i
);

    localparam int NumWords = OutW / EdnW;
    localparam int CntW     = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NumWords - 1);

    if ((OutW % EdnW) != 0 || (OutW / EdnW) < 2) begin : g_param_check
        $error("otbn_edn_packer: OutW must be a multiple of EdnW holding at least two words");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_e;

    state_e          state_reg, state_next;
    logic [CntW-1:0] count_reg, count_next;
    logic            fips_acc_reg, fips_acc_next;
    logic            err_acc_reg, err_acc_next;
    logic            word_accept;
    logic            word_err;

    // A word is only taken while filling, and a concurrent clear throws it away.
    assign word_accept = (state_reg == FILL) && edn_ack_i && !clear_i;
    assign ack_o       = (state_reg == FULL) && req_i && !clear_i;
    assign edn_req_o   = (state_reg == FILL);
    assign fips_o      = fips_acc_reg;
    assign err_o       = err_acc_reg;

`ifdef OTBN_EDN_REP_CHECK_EN
    logic [EdnW-1:0] prev_word_reg;
    logic            prev_valid_reg;
    logic            rep_hit;

    // History survives ack_o so repeats are caught across packed-word boundaries.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            prev_word_reg  <= '0;
            prev_valid_reg <= 1'b0;
        end else if (word_accept) begin
            prev_word_reg  <= edn_data_i;
            prev_valid_reg <= 1'b1;
        end
    end

    assign rep_hit  = prev_valid_reg && (edn_data_i == prev_word_reg);
    assign word_err = edn_err_i || rep_hit;
`else
    assign word_err = edn_err_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            fips_acc_reg <= 1'b1;
            err_acc_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            fips_acc_reg <= fips_acc_next;
            err_acc_reg  <= err_acc_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        fips_acc_next = fips_acc_reg;
        err_acc_next  = err_acc_reg;
        if (clear_i) begin
            // FILL keeps requesting and simply restarts at slot 0.
            count_next    = '0;
            fips_acc_next = 1'b1;
            err_acc_next  = 1'b0;
            if (state_reg != FILL) begin
                state_next = IDLE;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    count_next    = '0;
                    fips_acc_next = 1'b1;
                    err_acc_next  = 1'b0;
                    if (req_i) begin
                        state_next = FILL;
                    end
                end
                FILL: begin
                    if (edn_ack_i) begin
                        fips_acc_next = fips_acc_reg & edn_fips_i;
                        err_acc_next  = err_acc_reg | word_err;
                        if (count_reg == LastCnt) begin
                            count_next = '0;
                            state_next = FULL;
                        end else begin
                            count_next = count_reg + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (ack_o) begin
                        state_next    = IDLE;
                        count_next    = '0;
                        fips_acc_next = 1'b1;
                        err_acc_next  = 1'b0;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // One register per slot; word k lands in bits [EdnW*k +: EdnW] in arrival order.
    for (genvar gi = 0; gi < NumWords; gi++) begin : g_slot
        logic [EdnW-1:0] slot_reg;

        always_ff @(posedge clk_i) begin
            if (rst_i || clear_i) begin
                slot_reg <= '0;
            end else if (word_accept && (count_reg == CntW'(gi))) begin
                slot_reg <= edn_data_i;
            end
        end

        assign data_o[EdnW*gi +: EdnW] = slot_reg;
    end

`ifndef SYNTHESIS
    ack_in_full_a: assert property (@(posedge clk_i) disable iff (rst_i)
        ack_o |-> (state_reg == FULL));
    edn_ack_in_fill_a: assert property (@(posedge clk_i) disable iff (rst_i)
        edn_ack_i |-> (state_reg == FILL));
    edn_req_held_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (edn_req_o && !edn_ack_i) |=> edn_req_o);
    data_stable_full_a: assert property (@(posedge clk_i) disable iff (rst_i)
        ((state_reg == FULL) && !clear_i) |=> $stable(data_o));
`endif

endmodule

// File: tb/tb_otbn_edn_packer.sv
// Scoreboard bench for otbn_edn_packer: a word-list model predicts each packed result,
// and a monitor compares it whenever ack_o pulses.
module tb_otbn_edn_packer;

    localparam int OutW = 256;
    localparam int EdnW = 32;
    localparam int NW   = OutW / EdnW;

    logic            clk_i = 1'b0;
    logic            rst_i, clear_i, req_i, ack_o;
    logic [OutW-1:0] data_o;
    logic            fips_o, err_o, edn_req_o, edn_ack_i, edn_fips_i, edn_err_i;
    logic [EdnW-1:0] edn_data_i;

    always #5 clk_i = ~clk_i;

    otbn_edn_packer #(.OutW(OutW), .EdnW(EdnW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .req_i(req_i),
        .ack_o(ack_o), .data_o(data_o), .fips_o(fips_o), .err_o(err_o),
        .edn_req_o(edn_req_o), .edn_ack_i(edn_ack_i), .edn_data_i(edn_data_i),
        .edn_fips_i(edn_fips_i), .edn_err_i(edn_err_i)
    );

    typedef struct packed {
        logic [OutW-1:0] d;
        logic            f;
        logic            e;
    } exp_t;

    int n_chk = 0;
    int n_fail = 0;
    int acks_seen = 0;
    int n_tx = 0;
    exp_t sb[$];
    logic [EdnW-1:0] cur_w[$];
    logic cur_f = 1'b1;
    logic cur_e = 1'b0;
    logic [EdnW-1:0] prev_w = '0;
    logic prev_v = 1'b0;

    task automatic chk(input string name, input logic [OutW-1:0] act, input logic [OutW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: words accepted in order; every NW of them form one expected result.
    function automatic void m_accept(input logic [EdnW-1:0] w, input logic f, input logic e);
        exp_t x;
        logic ee;
        ee = e;
`ifdef OTBN_EDN_REP_CHECK_EN
        if (prev_v && (w == prev_w)) ee = 1'b1;
        prev_w = w;
        prev_v = 1'b1;
`endif
        cur_w.push_back(w);
        cur_f = cur_f & f;
        cur_e = cur_e | ee;
        if (cur_w.size() == NW) begin
            x.d = '0;
            for (int k = 0; k < NW; k++) x.d[EdnW*k +: EdnW] = cur_w[k];
            x.f = cur_f;
            x.e = cur_e;
            sb.push_back(x);
            cur_w.delete();
            cur_f = 1'b1;
            cur_e = 1'b0;
        end
    endfunction

    function automatic void m_clear();
        cur_w.delete();
        cur_f = 1'b1;
        cur_e = 1'b0;
        prev_v = 1'b0;
        sb.delete();
    endfunction

    // Monitor: every ack_o must match the oldest outstanding expected result.
    always @(negedge clk_i) begin
        exp_t x;
        if (!rst_i && ack_o) begin
            acks_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_ack", 1'b1, 1'b0);
            end else begin
                x = sb.pop_front();
                chk("data", data_o, x.d);
                chk("fips", fips_o, x.f);
                chk("err", err_o, x.e);
                $display("ack #%0d data=%h fips=%0b err=%0b", acks_seen, data_o, fips_o, err_o);
            end
        end
    end

    task automatic do_reset();
        rst_i = 1'b1; clear_i = 1'b0; req_i = 1'b0; edn_ack_i = 1'b0;
        m_clear();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic cyc(input logic req, input logic clr, input logic try_ack, input logic [EdnW-1:0] w,
                       input logic f, input logic e, output logic acked, output logic reqd);
        req_i = req;
        clear_i = clr;
        reqd = edn_req_o;
        edn_ack_i = try_ack && edn_req_o;
        edn_data_i = w;
        edn_fips_i = f;
        edn_err_i = e;
        if (clr) m_clear();
        else if (edn_ack_i) m_accept(w, f, e);
        #1;
        acked = ack_o;
        @(posedge clk_i); #1;
    endtask

    // One packed-word request. hold=0 pulses req_i only in the first cycle (prefetch).
    task automatic do_fill(input logic [EdnW-1:0] base, input logic [EdnW-1:0] step, input bit rnd,
                           input logic [NW-1:0] fm, input logic [NW-1:0] em, input int gap_max,
                           input bit hold, input int clr_at_i, input int rst_at_i,
                           output int lat, output int req_cyc);
        int k, seq, kk, clr_at, rst_at;
        logic go, clr, a, r;
        logic [EdnW-1:0] w, last;
        k = 0; seq = 0; lat = -1; req_cyc = 0; last = base;
        clr_at = clr_at_i; rst_at = rst_at_i;
        for (int c = 0; c < 400; c++) begin
            if (lat >= 0 || (!hold && k == NW)) break;
            go = (k < NW) && (gap_max == 0 || $urandom_range(gap_max, 0) == 0);
            if (rnd) w = ($urandom_range(7, 0) == 0) ? last : $urandom();
            else w = base + EdnW'(seq) * step;
            kk = (k < NW) ? k : 0;
            if (edn_req_o && go && k == rst_at) begin
                do_reset();
                chk("rst_edn_req", edn_req_o, 1'b0);
                rst_at = -1;
                k = 0;
                continue;
            end
            clr = edn_req_o && go && (k == clr_at);
            cyc(hold || c == 0, clr, go, w, fm[kk], em[kk], a, r);
            if (r && go) begin
                seq++;
                last = w;
                if (clr) begin k = 0; clr_at = -1; end
                else k++;
            end
            if (r) req_cyc++;
            if (a) lat = c;
        end
        req_i = 1'b0; edn_ack_i = 1'b0; clear_i = 1'b0;
        if (hold && lat < 0) chk("fill_timeout", 1'b1, 1'b0);
        if (!hold && k != NW) chk("prefetch_timeout", 1'b1, 1'b0);
    endtask

    task automatic idle_quiet(input int n, output int bad);
        logic a, r;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, a, r);
            if (a || r) bad++;
        end
    endtask

    initial begin
        int lat, rc, bad, gap, clr_at;
        bit hold;
        logic a, r;
        logic [NW-1:0] fm, em;
        rst_i = 1'b0; clear_i = 1'b0; req_i = 1'b0; edn_ack_i = 1'b0;
        edn_data_i = '0; edn_fips_i = 1'b0; edn_err_i = 1'b0;
        @(posedge clk_i); #1;
        do_reset();
        chk("rst_ack", ack_o, 1'b0);
        chk("rst_edn_req", edn_req_o, 1'b0);
        chk("rst_data", data_o, '0);
        chk("rst_fips", fips_o, 1'b1);
        chk("rst_err", err_o, 1'b0);

        // Basic fill: words 1..8 back to back.
        do_fill(32'h1, 32'h1, 0, '1, '0, 0, 1, -1, -1, lat, rc); n_tx++;
        chk("basic_latency", lat, NW + 1);
        chk("basic_req_cycles", rc, NW);

        // Flag reduction, then a clean word.
        do_fill(32'h11, 32'h1, 0, 8'b1111_1011, 8'b0010_0000, 0, 1, -1, -1, lat, rc); n_tx++;
        do_fill(32'h21, 32'h1, 0, '1, '0, 0, 1, -1, -1, lat, rc); n_tx++;
        // First word repeats the last word of the previous packed word.
        do_fill(32'h28, 32'h1, 0, '1, '0, 0, 1, -1, -1, lat, rc); n_tx++;

        // Prefetch hold: single-cycle req, then a long idle gap.
        do_fill(32'h200, 32'h1, 0, '1, '0, 0, 0, -1, -1, lat, rc);
        idle_quiet(20, bad);
        chk("hold_quiet", bad, 0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, a, r); n_tx++;
        chk("prefetch_ack", a, 1'b1);
        chk("prefetch_no_req", r, 1'b0);

        // Clear while FULL drops the prefetched word.
        do_fill(32'h300, 32'h1, 0, '1, '0, 0, 0, -1, -1, lat, rc);
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, a, r);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, a, r);
        chk("clr_full_noack", a, 1'b0);
        chk("clr_full_data", data_o, '0);
        do_fill(32'h400, 32'h1, 0, '1, '0, 0, 1, -1, -1, lat, rc); n_tx++;

        // Clear together with the 6th EDN ack.
        do_fill(32'h500, 32'h1, 0, '1, '0, 0, 1, 5, -1, lat, rc); n_tx++;
        chk("clear_latency", lat, 15);
        chk("clear_req_cycles", rc, 14);

        // Repeated identical words.
        do_fill(32'hA5A5A5A5, 32'h0, 0, '1, '0, 0, 1, -1, -1, lat, rc); n_tx++;

        // Reset after 3 words, then a full refill.
        do_fill(32'h600, 32'h1, 0, '1, '0, 0, 1, -1, 3, lat, rc); n_tx++;

        // Randomized traffic.
        for (int t = 0; t < 25; t++) begin
            hold = ($urandom_range(3, 0) != 0);
            gap = $urandom_range(3, 0);
            fm = ($urandom_range(3, 0) == 0) ? NW'($urandom()) : '1;
            em = ($urandom_range(3, 0) == 0) ? NW'($urandom()) : '0;
            clr_at = ($urandom_range(4, 0) == 0) ? $urandom_range(NW - 1, 0) : -1;
            do_fill('0, '0, 1, fm, em, gap, hold, clr_at, -1, lat, rc); n_tx++;
            if (!hold) begin
                idle_quiet($urandom_range(5, 0), bad);
                chk("rnd_hold_quiet", bad, 0);
                cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, a, r);
                chk("rnd_prefetch_ack", a, 1'b1);
            end
        end

        idle_quiet(4, bad);
        chk("final_quiet", bad, 0);
        chk("sb_drained", sb.size(), 0);
        chk("ack_count", acks_seen, n_tx);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
